// File: rtl/loader_pkg.sv
// Shared types and sizing for the instruction-memory loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
    DONE,
    ERR
  } loader_state_t;

  localparam int unsigned BYTES_PER_WORD     = 4;
  localparam int unsigned BYTE_W             = 8;
  localparam int unsigned WORD_W             = 32;
  localparam int unsigned IDX_W              = 2;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 100000;

  // Bits needed to hold the value 'cycles', i.e. $clog2(cycles+1).
  function automatic int unsigned tmo_width(input int unsigned cycles);
    int unsigned w;
    w = 1;
    while ((cycles >> w) != 0) w++;
    return w;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Little-endian 4-byte assembler; the byte presented with 'load' is merged into word_c.
module byte_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [BYTE_W-1:0] data,
  output logic [WORD_W-1:0] word_c,
  output logic              word_full_c
);

  logic [WORD_W-1:0] word_q;
  logic [IDX_W-1:0]  idx_q;

  // Current word with the incoming byte inserted at its lane.
  always_comb begin
    word_c = word_q;
    if (load) word_c[{idx_q, 3'b000} +: BYTE_W] = data;
  end

  assign word_full_c = load && (idx_q == IDX_W'(BYTES_PER_WORD - 1));

  // Index wraps naturally to 0 after the last lane; a full word restarts from zero.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (load) begin
      word_q <= word_full_c ? '0 : word_c;
      idx_q  <= idx_q + IDX_W'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Length-prefixed byte stream to instruction-memory word writes; holds the core in reset until loaded.
module imem_loader
  import loader_pkg::*;
#(
  parameter logic [WORD_W-1:0] BASE_ADDR      = 32'd4,
  parameter int unsigned       MAX_WORDS      = 1024,
  parameter int unsigned       TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              core_rst,
  output logic              load_done,
  output logic              load_err,
  output logic [WORD_W-1:0] words_loaded
);

  localparam int unsigned TMO_W = tmo_width(TIMEOUT_CYCLES);

  loader_state_t     state, state_next;
  logic [WORD_W-1:0] count_q, count_next;
  logic [TMO_W-1:0]  tmo_q, tmo_next;
  logic [WORD_W-1:0] addr_next, wdata_next, words_next;
  logic              rx_ready_next, mem_we_next, core_rst_next, done_next, err_next;
  logic              accept;
  logic              pk_load, pk_clear, pk_full;
  logic [WORD_W-1:0] pk_word;

  assign accept = rx_valid && rx_ready;

  byte_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .load        (pk_load),
    .clear       (pk_clear),
    .data        (rx_data),
    .word_c      (pk_word),
    .word_full_c (pk_full)
  );

  // Next-state and next-output decode; the packer serves both header and data words.
  always_comb begin
    state_next = state;
    count_next = count_q;
    tmo_next   = '0;
    addr_next  = mem_addr;
    wdata_next = mem_wdata;
    words_next = words_loaded;
    pk_load    = 1'b0;
    pk_clear   = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          pk_load    = 1'b1;
          state_next = LEN;
        end
      end
      LEN, DATA: begin
        pk_load = accept;
        if (accept) begin
          if (pk_full && state == LEN) begin
            count_next = pk_word;
            if (pk_word == '0)                         state_next = DONE;
            else if (pk_word > WORD_W'(MAX_WORDS))     state_next = ERR;
            else                                       state_next = DATA;
          end else if (pk_full) begin
            wdata_next = pk_word;
            state_next = WRITE;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          // An accepted byte on this same cycle takes the branch above instead.
          state_next = ERR;
          pk_clear   = 1'b1;
        end else begin
          tmo_next = tmo_q + TMO_W'(1);
        end
      end
      WRITE: begin
        words_next = words_loaded + WORD_W'(1);
        addr_next  = mem_addr + WORD_W'(4);
        state_next = (words_next == count_q) ? DONE : DATA;
      end
      DONE, ERR: pk_clear = 1'b1;
      default:   state_next = IDLE;
    endcase

    rx_ready_next = (state_next == IDLE) || (state_next == LEN) || (state_next == DATA);
    mem_we_next   = (state_next == WRITE);
    done_next     = (state_next == DONE);
    err_next      = (state_next == ERR);
    core_rst_next = !done_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      count_q      <= '0;
      tmo_q        <= '0;
      rx_ready     <= 1'b1;
      mem_we       <= 1'b0;
      mem_addr     <= BASE_ADDR;
      mem_wdata    <= '0;
      core_rst     <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
    end else begin
      state        <= state_next;
      count_q      <= count_next;
      tmo_q        <= tmo_next;
      rx_ready     <= rx_ready_next;
      mem_we       <= mem_we_next;
      mem_addr     <= addr_next;
      mem_wdata    <= wdata_next;
      core_rst     <= core_rst_next;
      load_done    <= done_next;
      load_err     <= err_next;
      words_loaded <= words_next;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: byte-count based reference model, per-cycle compare, directed and random loads.
module tb_imem_loader;

  localparam logic [31:0] BASE    = 32'd4;
  localparam int          MAXW    = 1024;
  localparam int          TIMEOUT = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready, mem_we, core_rst, load_done, load_err;
  logic [31:0] mem_addr, mem_wdata, words_loaded;

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_rst(core_rst),
    .load_done(load_done), .load_err(load_err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: counts accepted bytes; first four form the header, every further four a word.
  bit          m_valid = 1'b0;
  bit          m_ready, m_we, m_done, m_err, m_acc;
  int          m_nb, m_idle;
  int unsigned m_words;
  logic [31:0] m_count, m_word, m_wdata;

  always @(posedge clk) begin
    if (!rst) begin
      m_valid = 1'b1; m_ready = 1'b1; m_we = 1'b0; m_done = 1'b0; m_err = 1'b0; m_acc = 1'b0;
      m_nb = 0; m_idle = 0; m_words = 0; m_count = '0; m_word = '0; m_wdata = '0;
    end else begin
      m_acc = rx_valid && m_ready;
      if (m_we) begin
        m_we = 1'b0;
        m_words++;
        if (m_words == m_count) m_done = 1'b1;
        m_ready = !m_done;
      end else if (!m_done && !m_err) begin
        if (m_acc) begin
          m_idle = 0;
          if (m_nb < 4) m_count = m_count | (32'(rx_data) << (8 * m_nb));
          else          m_word  = m_word  | (32'(rx_data) << (8 * ((m_nb - 4) % 4)));
          m_nb++;
          if (m_nb == 4) begin
            if (m_count == 0)                     begin m_done = 1'b1; m_ready = 1'b0; end
            else if (m_count > 32'(MAXW))         begin m_err  = 1'b1; m_ready = 1'b0; end
          end else if (m_nb > 4 && (m_nb - 4) % 4 == 0) begin
            m_we = 1'b1; m_ready = 1'b0; m_wdata = m_word; m_word = '0;
          end
        end else if (m_nb > 0) begin
          m_idle++;
          if (m_idle == TIMEOUT) begin m_err = 1'b1; m_ready = 1'b0; end
        end
      end
    end
  end

  // Observed writes, for directed literal checks.
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    logic [100:0] exp_v, act_v;
    if (m_valid) begin
      if (mem_we === 1'b1) begin
        wr_addr.push_back(mem_addr);
        wr_data.push_back(mem_wdata);
      end
      exp_v = {m_ready, m_we, !m_done, m_done, m_err, BASE + 32'(4 * m_words), m_wdata, 32'(m_words)};
      act_v = {rx_ready, mem_we, core_rst, load_done, load_err, mem_addr, mem_wdata, words_loaded};
      n_checks++;
      if (act_v === exp_v) n_pass++;
      else $display("FAIL cycle t=%0t: got rdy/we/crst/done/err=%b%b%b%b%b addr=%h wdata=%h words=%0d, expected %b%b%b%b%b addr=%h wdata=%h words=%0d",
                    $time, rx_ready, mem_we, core_rst, load_done, load_err, mem_addr, mem_wdata, words_loaded,
                    exp_v[100], exp_v[99], exp_v[98], exp_v[97], exp_v[96], exp_v[95:64], exp_v[63:32], exp_v[31:0]);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Present one byte after 'gap' idle cycles and hold it until the model accepts it.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      ok = m_acc;
    end
    if (!ok) begin
      chk("handshake", 32'(rx_ready), 32'(1));
      rx_valid = 1'b0;
    end
  endtask

  task automatic send_bytes(input logic [7:0] q[$], input int maxgap);
    foreach (q[i]) send_byte(q[i], (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  q[$];
    logic [31:0] hdr;
    int          mode, nw, cut;

    // Reset values
    repeat (2) @(negedge clk);
    chk("reset rx_ready", 32'(rx_ready), 32'(1));
    chk("reset mem_addr", mem_addr, 32'h4);
    chk("reset core_rst", 32'(core_rst), 32'(1));
    chk("reset words", words_loaded, 32'h0);
    rst = 1'b1;

    // Two-word load, rx_valid held high throughout
    wr_addr.delete(); wr_data.delete();
    q = '{8'h02,8'h00,8'h00,8'h00, 8'h13,8'h05,8'h10,8'h00, 8'h93,8'h05,8'h20,8'h00};
    foreach (q[i]) send_byte(q[i], 0);
    chk("2w second write we", 32'(mem_we), 32'(1));
    chk("2w second write addr", mem_addr, 32'h8);
    chk("2w second write data", mem_wdata, 32'h0020_0593);
    chk("2w ready low in write", 32'(rx_ready), 32'(0));
    @(negedge clk);
    chk("2w load_done", 32'(load_done), 32'(1));
    chk("2w core_rst", 32'(core_rst), 32'(0));
    chk("2w words", words_loaded, 32'd2);
    // Post-DONE bytes are ignored
    rx_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin rx_data = 8'($urandom); @(negedge clk); end
    rx_valid = 1'b0;
    chk("2w write count", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() >= 2) begin
      chk("2w first addr", wr_addr[0], 32'h4);
      chk("2w first data", wr_data[0], 32'h0010_0513);
    end
    chk("post-done words", words_loaded, 32'd2);

    // Zero-length header
    reset_dut(); wr_addr.delete(); wr_data.delete();
    q = '{8'h00,8'h00,8'h00,8'h00};
    send_bytes(q, 0);
    chk("zero load_done", 32'(load_done), 32'(1));
    chk("zero core_rst", 32'(core_rst), 32'(0));
    idle(3);
    chk("zero no writes", 32'(wr_addr.size()), 32'd0);

    // Oversize header 1025
    reset_dut(); wr_addr.delete();
    q = '{8'h01,8'h04,8'h00,8'h00};
    send_bytes(q, 0);
    chk("oversize load_err", 32'(load_err), 32'(1));
    chk("oversize core_rst", 32'(core_rst), 32'(1));
    chk("oversize rx_ready", 32'(rx_ready), 32'(0));
    idle(3);
    chk("oversize no writes", 32'(wr_addr.size()), 32'd0);

    // Stall mid-word: 9 idle cycles still fine, the 10th errors
    reset_dut(); wr_addr.delete();
    q = '{8'h01,8'h00,8'h00,8'h00, 8'hAA,8'hBB};
    send_bytes(q, 0);
    idle(9);
    chk("stall 9 no err", 32'(load_err), 32'(0));
    idle(1);
    chk("stall 10 err", 32'(load_err), 32'(1));
    idle(3);
    chk("stall no writes", 32'(wr_addr.size()), 32'd0);

    // Byte arriving on the 10th idle cycle wins over the timeout
    reset_dut(); wr_addr.delete(); wr_data.delete();
    q = '{8'h01,8'h00,8'h00,8'h00, 8'hAA,8'hBB};
    send_bytes(q, 0);
    send_byte(8'hCC, 9);
    chk("edge byte no err", 32'(load_err), 32'(0));
    send_byte(8'hDD, 0);
    rx_valid = 1'b0;
    idle(2);
    chk("edge load_done", 32'(load_done), 32'(1));
    if (wr_data.size() == 1) chk("edge word", wr_data[0], 32'hDDCC_BBAA);
    else chk("edge write count", 32'(wr_data.size()), 32'd1);

    // Reset after the first of three words
    reset_dut(); wr_addr.delete();
    q = '{8'h03,8'h00,8'h00,8'h00, 8'h11,8'h22,8'h33,8'h44};
    send_bytes(q, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("midrst mem_addr", mem_addr, 32'h4);
    chk("midrst words", words_loaded, 32'h0);
    chk("midrst core_rst", 32'(core_rst), 32'(1));
    chk("midrst rx_ready", 32'(rx_ready), 32'(1));
    wr_addr.delete(); wr_data.delete();
    q = '{8'h01,8'h00,8'h00,8'h00, 8'hEF,8'hBE,8'hAD,8'hDE};
    send_bytes(q, 0);
    idle(2);
    if (wr_addr.size() == 1) begin
      chk("fresh addr", wr_addr[0], 32'h4);
      chk("fresh data", wr_data[0], 32'hDEAD_BEEF);
    end else chk("fresh write count", 32'(wr_addr.size()), 32'd1);

    // Randomized loads: normal, oversize and stalled
    for (int t = 0; t < 30; t++) begin
      reset_dut();
      mode = $urandom_range(0, 9);
      nw   = $urandom_range(1, 6);
      hdr  = (mode == 8) ? 32'($urandom_range(1025, 70000)) : 32'(nw);
      q = {};
      for (int i = 0; i < 4; i++) q.push_back(8'(hdr >> (8 * i)));
      if (mode != 8) for (int i = 0; i < 4 * nw; i++) q.push_back(8'($urandom));
      if (mode == 9) begin
        cut = $urandom_range(1, q.size() - 1);
        while (q.size() > cut) void'(q.pop_back());
      end
      send_bytes(q, TIMEOUT - 1);
      idle((mode == 9) ? TIMEOUT + 3 : 8);
      rx_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin rx_data = 8'($urandom); @(negedge clk); end
      rx_valid = 1'b0;
      idle(2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Upstream program-load stage for the core's instruction memory. Receives a length-prefixed byte stream (from a UART or bench driver) and packs it into little-endian 32-bit words. Writes each word into instruction memory at consecutive word addresses starting at BASE_ADDR.
- Holds the core in reset while loading and releases it once the image is complete. This replaces the file-dump preload with a synthesizable path.

Parameters:
- BASE_ADDR, 32'd4, byte address of the first loaded word; increments by 4 per word.
- MAX_WORDS, 1024, largest accepted word count; a larger header is an error.
- TIMEOUT_CYCLES, 100000, idle cycles allowed between accepted bytes once a transfer has started.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-low reset
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader can accept a byte
- mem_we  out  1  one-cycle instruction-memory write strobe
- mem_addr  out  32  byte address of the write
- mem_wdata  out  32  word to write
- core_rst  out  1  active-high reset to core; 1 while loading
- load_done  out  1  image fully written, sticky
- load_err  out  1  protocol/timeout error, sticky
- words_loaded  out  32  count of words written so far

Behaviour:
- Byte handshake: a byte is accepted at a posedge with rx_valid=1 and rx_ready=1. rx_data is ignored otherwise.
- Reset values (rst=0 at posedge):
  - state IDLE, rx_ready=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0.
  - core_rst=1, load_done=0, load_err=0, words_loaded=0, timeout counter=0.
- Reset mid-operation returns everything to these values. Memory already written is not cleared.
- States are IDLE, LEN, DATA, WRITE, DONE, ERR.
- IDLE: no timeout. The first accepted byte becomes count[7:0] and the block moves to LEN with byte index 1.
- LEN: collect bytes 1..3 into count[15:8], [23:16], [31:24]. After the 4th byte:
  - count==0 -> DONE.
  - count>MAX_WORDS -> ERR.
  - otherwise -> DATA with byte index 0.
- DATA: collect 4 bytes little-endian; the first byte received is word[7:0]. On the 4th accepted byte, go to WRITE the next cycle.
- WRITE (exactly 1 cycle):
  - mem_we=1, with mem_addr=BASE_ADDR+4*words_loaded and mem_wdata=the assembled word. rx_ready=0.
  - At the end of the cycle, words_loaded increments and mem_addr advances by 4 (wraps modulo 2^32).
  - If the new words_loaded==count -> DONE, else -> DATA.
- Latency: mem_we asserts 1 cycle after the 4th byte of a word is accepted. Sustained rate is 1 word per 5 cycles.
- DONE:
  - load_done=1 and core_rst=0, both registered and first visible the cycle after entering DONE.
  - rx_ready=0; further bytes are ignored. The block stays in DONE until reset.
- Timeout: in LEN and DATA, the counter increments on each cycle with no accepted byte and clears on each accepted byte.
  - The counter reaching TIMEOUT_CYCLES -> ERR.
  - The counter is held at 0 in IDLE, WRITE, DONE and ERR.
- ERR: load_err=1, core_rst stays 1, rx_ready=0, no further writes. Sticky until reset.
- Simultaneous events: a byte accepted on the same cycle the counter would reach TIMEOUT_CYCLES wins; the counter clears and there is no error.
- mem_we is never asserted outside WRITE. mem_addr and mem_wdata hold their last values when mem_we=0.
- words_loaded never exceeds count.

Decomposition:
- Package loader_pkg holds:
  - the state enum loader_state_t {IDLE, LEN, DATA, WRITE, DONE, ERR}
  - the constant BYTES_PER_WORD=4
  - the width localparam for the timeout counter, $clog2(TIMEOUT_CYCLES+1)
- One sub-module, byte_packer: 4-byte little-endian shift/insert register with a 2-bit index.
  - Inputs: clk, rst, load strobe, byte, clear.
  - Outputs: assembled word and a word_full pulse.
  - Used for both the count header and the data words.

Test Plan:
- Load 2 words: send bytes 02 00 00 00, 13 05 10 00, 93 05 20 00.
  - mem_we pulses twice: addr 0x4 data 0x00100513, then addr 0x8 data 0x00200593.
  - words_loaded=2; load_done=1 and core_rst=0 one cycle after the second write.
- Zero-length header 00 00 00 00 -> no mem_we, load_done=1, core_rst=0, words_loaded=0.
- Oversize header with MAX_WORDS=1024: send 01 04 00 00 (1025) -> load_err=1, core_rst=1, rx_ready=0, no writes.
- Stall mid-word with TIMEOUT_CYCLES=10: header 01 00 00 00, then AA BB, then rx_valid=0 for 10 cycles -> load_err=1 and no write.
  - Repeat with a byte arriving on the 10th idle cycle -> no error.
- Reset mid-load: rst=0 for 1 cycle after the first of 3 words is written.
  - All outputs return to reset values (mem_addr=0x4, words_loaded=0, core_rst=1).
  - A fresh 1-word load then writes to 0x4.
- Backpressure and post-DONE: rx_valid held at 1 continuously -> rx_ready is 0 during each WRITE cycle and no byte is lost.
  - Bytes sent after DONE cause no writes and no change to words_loaded.
